csr_file: RTL and testbench

Machine-mode control/status register file for the pipelined RV32 core. It is the responder to the decode-side CSR control: it executes CSRRW/CSRRS/CSRRC and their immediate forms when the controller's `CSRWrite` reaches writeback. It maintains the 64-bit cycle and instret counters and performs trap-entry and `mret` state updates. It sits beside the register file in the writeback stage and supplies `mtvec`/`mepc` to the PC-select logic.

---
 rtl/csr_file.sv | 176 +++++++++++++++++
 tb/tb_csr_file.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/csr_file.sv
// csr_file -- machine-mode CSR file for the pipelined RV32 core.
//
// Executes CSRRW/CSRRS/CSRRC (and immediate forms) at writeback, keeps the
// 64-bit cycle and instret counters, and applies trap-entry / mret updates
// to mstatus, mepc and mcause.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   CSRWriteW          commit a CSR write this cycle
//   csr_addrW          12-bit CSR address
//   csr_funct3W        operation: 001 RW, 010 RS, 011 RC, 101/110/111 imm forms
//   rs1_dataW, zimmW   register / zero-extended immediate operand
//   InstrRetiredW      one instruction retired this cycle
//   TrapW, TrapCauseW, TrapPCW   trap entry request, cause, faulting PC
//   MretW              mret retiring this cycle
//   csr_rdataW         pre-write value of the addressed CSR (0 if unimplemented)
//   mtvec_o, mepc_o    trap target / mret target
//   mie_o              mstatus.MIE
//   illegal_csrW       unimplemented address, or write to a read-only CSR
module csr_file #(
   parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
   parameter logic [31:0] HART_ID     = 32'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        CSRWriteW,
   input  logic [11:0] csr_addrW,
   input  logic [2:0]  csr_funct3W,
   input  logic [31:0] rs1_dataW,
   input  logic [4:0]  zimmW,
   input  logic        InstrRetiredW,
   input  logic        TrapW,
   input  logic [31:0] TrapCauseW,
   input  logic [31:0] TrapPCW,
   input  logic        MretW,
   output logic [31:0] csr_rdataW,
   output logic [31:0] mtvec_o,
   output logic [31:0] mepc_o,
   output logic        mie_o,
   output logic        illegal_csrW
);

   localparam logic [11:0] A_MSTATUS   = 12'h300;
   localparam logic [11:0] A_MISA      = 12'h301;
   localparam logic [11:0] A_MTVEC     = 12'h305;
   localparam logic [11:0] A_MSCRATCH  = 12'h340;
   localparam logic [11:0] A_MEPC      = 12'h341;
   localparam logic [11:0] A_MCAUSE    = 12'h342;
   localparam logic [11:0] A_MCYCLE    = 12'hB00;
   localparam logic [11:0] A_MINSTRET  = 12'hB02;
   localparam logic [11:0] A_MCYCLEH   = 12'hB80;
   localparam logic [11:0] A_MINSTRETH = 12'hB82;
   localparam logic [11:0] A_CYCLE     = 12'hC00;
   localparam logic [11:0] A_INSTRET   = 12'hC02;
   localparam logic [11:0] A_CYCLEH    = 12'hC80;
   localparam logic [11:0] A_INSTRETH  = 12'hC82;
   localparam logic [11:0] A_MHARTID   = 12'hF14;

   localparam logic [31:0] MISA_VALUE  = 32'h4000_0100;

   // Architectural state
   logic        mie, mpie;
   logic [31:0] mtvec, mscratch, mepc, mcause;
   logic [63:0] mcycle, minstret;

   // Decode / datapath
   logic        implemented, read_only, op_valid, wr;
   logic [31:0] old_val, src, wdata;
   logic [32:0] cyc_lo_sum, ir_lo_sum;
   logic [31:0] cyc_lo_next, cyc_hi_next, ir_lo_next, ir_hi_next;

   // Address decode and read mux
   always_comb begin
      implemented = 1'b1;
      read_only   = 1'b0;
      old_val     = '0;
      case (csr_addrW)
         A_MSTATUS:   old_val = {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie, 3'b0};
         A_MISA:      begin old_val = MISA_VALUE;       read_only = 1'b1; end
         A_MTVEC:     old_val = mtvec;
         A_MSCRATCH:  old_val = mscratch;
         A_MEPC:      old_val = mepc;
         A_MCAUSE:    old_val = mcause;
         A_MCYCLE:    old_val = mcycle[31:0];
         A_MCYCLEH:   old_val = mcycle[63:32];
         A_MINSTRET:  old_val = minstret[31:0];
         A_MINSTRETH: old_val = minstret[63:32];
         A_CYCLE:     begin old_val = mcycle[31:0];     read_only = 1'b1; end
         A_CYCLEH:    begin old_val = mcycle[63:32];    read_only = 1'b1; end
         A_INSTRET:   begin old_val = minstret[31:0];   read_only = 1'b1; end
         A_INSTRETH:  begin old_val = minstret[63:32];  read_only = 1'b1; end
         A_MHARTID:   begin old_val = HART_ID;          read_only = 1'b1; end
         default:     implemented = 1'b0;
      endcase
   end

   assign csr_rdataW   = old_val;
   assign illegal_csrW = !implemented || (CSRWriteW && read_only);

   // Write value: funct3[2] selects the immediate, funct3[1:0] the operation
   always_comb begin
      src      = csr_funct3W[2] ? {27'b0, zimmW} : rs1_dataW;
      op_valid = 1'b1;
      wdata    = old_val;
      case (csr_funct3W[1:0])
         2'b01:   wdata = src;
         2'b10:   wdata = old_val | src;
         2'b11:   wdata = old_val & ~src;
         default: op_valid = 1'b0;
      endcase
   end

   // A trap drops any write retiring alongside it
   assign wr = CSRWriteW && op_valid && !illegal_csrW && !TrapW;

   // Counters: a written half takes the written value; the other half still
   // advances from the pre-write value, so a carry out of an unwritten low
   // half still lands in the high half this cycle.
   always_comb begin
      cyc_lo_sum  = {1'b0, mcycle[31:0]} + 33'd1;
      cyc_lo_next = cyc_lo_sum[31:0];
      cyc_hi_next = mcycle[63:32] + {31'b0, cyc_lo_sum[32]};
      if (wr && csr_addrW == A_MCYCLE)  cyc_lo_next = wdata;
      if (wr && csr_addrW == A_MCYCLEH) cyc_hi_next = wdata;

      ir_lo_sum   = {1'b0, minstret[31:0]} + {32'b0, InstrRetiredW};
      ir_lo_next  = ir_lo_sum[31:0];
      ir_hi_next  = minstret[63:32] + {31'b0, ir_lo_sum[32]};
      if (wr && csr_addrW == A_MINSTRET)  ir_lo_next = wdata;
      if (wr && csr_addrW == A_MINSTRETH) ir_hi_next = wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mie      <= 1'b0;
         mpie     <= 1'b0;
         mtvec    <= RESET_MTVEC & 32'hFFFF_FFFC;
         mscratch <= '0;
         mepc     <= '0;
         mcause   <= '0;
         mcycle   <= '0;
         minstret <= '0;
      end else begin
         mcycle   <= {cyc_hi_next, cyc_lo_next};
         minstret <= {ir_hi_next, ir_lo_next};

         // mstatus: trap beats mret beats a CSR write
         if (TrapW) begin
            mpie <= mie;
            mie  <= 1'b0;
         end else if (MretW) begin
            mie  <= mpie;
            mpie <= 1'b1;
         end else if (wr && csr_addrW == A_MSTATUS) begin
            mie  <= wdata[3];
            mpie <= wdata[7];
         end

         if (TrapW) begin
            mepc   <= TrapPCW & 32'hFFFF_FFFC;
            mcause <= TrapCauseW;
         end else begin
            if (wr && csr_addrW == A_MEPC)   mepc   <= wdata & 32'hFFFF_FFFC;
            if (wr && csr_addrW == A_MCAUSE) mcause <= wdata;
         end

         if (wr && csr_addrW == A_MTVEC)    mtvec    <= wdata & 32'hFFFF_FFFC;
         if (wr && csr_addrW == A_MSCRATCH) mscratch <= wdata;
      end
   end

   assign mtvec_o = mtvec;
   assign mepc_o  = mepc;
   assign mie_o   = mie;

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file -- directed self-checking bench for csr_file.
// Inputs change 1 ns after the rising edge; outputs are checked once the
// combinational paths have settled, well before the next edge.
module tb_csr_file;

   logic        clk;
   logic        reset;
   logic        CSRWriteW;
   logic [11:0] csr_addrW;
   logic [2:0]  csr_funct3W;
   logic [31:0] rs1_dataW;
   logic [4:0]  zimmW;
   logic        InstrRetiredW;
   logic        TrapW;
   logic [31:0] TrapCauseW;
   logic [31:0] TrapPCW;
   logic        MretW;
   logic [31:0] csr_rdataW;
   logic [31:0] mtvec_o;
   logic [31:0] mepc_o;
   logic        mie_o;
   logic        illegal_csrW;

   int unsigned checks = 0;
   int unsigned errors = 0;

   csr_file #(
      .RESET_MTVEC (32'h0000_0100),
      .HART_ID     (32'd3)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .CSRWriteW     (CSRWriteW),
      .csr_addrW     (csr_addrW),
      .csr_funct3W   (csr_funct3W),
      .rs1_dataW     (rs1_dataW),
      .zimmW         (zimmW),
      .InstrRetiredW (InstrRetiredW),
      .TrapW         (TrapW),
      .TrapCauseW    (TrapCauseW),
      .TrapPCW       (TrapPCW),
      .MretW         (MretW),
      .csr_rdataW    (csr_rdataW),
      .mtvec_o       (mtvec_o),
      .mepc_o        (mepc_o),
      .mie_o         (mie_o),
      .illegal_csrW  (illegal_csrW)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Read a CSR without writing; checks data and the illegal flag
   task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp,
                     input logic exp_ill);
      CSRWriteW = 1'b0;
      csr_addrW = a;
      #1;
      chk(tag, csr_rdataW, exp);
      chk({tag, "_ill"}, {31'b0, illegal_csrW}, {31'b0, exp_ill});
   endtask

   task automatic wr(input logic [11:0] a, input logic [2:0] f, input logic [31:0] r,
                     input logic [4:0] z);
      CSRWriteW   = 1'b1;
      csr_addrW   = a;
      csr_funct3W = f;
      rs1_dataW   = r;
      zimmW       = z;
      #1;
   endtask

   // Advance one clock and drop all single-cycle strobes
   task automatic cycle();
      @(posedge clk);
      #1;
      CSRWriteW     = 1'b0;
      TrapW         = 1'b0;
      MretW         = 1'b0;
      InstrRetiredW = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; CSRWriteW = 1'b0; csr_addrW = '0; csr_funct3W = '0;
      rs1_dataW = '0; zimmW = '0; InstrRetiredW = 1'b0; TrapW = 1'b0;
      TrapCauseW = '0; TrapPCW = '0; MretW = 1'b0;

      // Reset, then five idle edges
      #15 reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rd("mcycle_idle5",  12'hB00, 32'd5, 1'b0);
      rd("mcycleh_idle5", 12'hB80, 32'd0, 1'b0);
      rd("cycle_shadow",  12'hC00, 32'd5, 1'b0);
      rd("minstret_idle", 12'hB02, 32'd0, 1'b0);
      rd("mstatus_rst",   12'h300, 32'h0000_1800, 1'b0);
      rd("misa",          12'h301, 32'h4000_0100, 1'b0);
      rd("mhartid",       12'hF14, 32'd3, 1'b0);
      rd("mtvec_rst",     12'h305, 32'h0000_0100, 1'b0);
      chk("mtvec_o_rst", mtvec_o, 32'h0000_0100);
      chk("mie_o_rst", {31'b0, mie_o}, 32'd0);

      // mscratch RW / RC / RSI
      wr(12'h340, 3'b001, 32'hDEAD_BEEF, 5'd0);
      chk("rw_old", csr_rdataW, 32'd0);
      cycle();
      rd("rw_new", 12'h340, 32'hDEAD_BEEF, 1'b0);
      wr(12'h340, 3'b011, 32'h0000_FFFF, 5'd0);
      chk("rc_old", csr_rdataW, 32'hDEAD_BEEF);
      cycle();
      rd("rc_new", 12'h340, 32'hDEAD_0000, 1'b0);
      wr(12'h340, 3'b110, 32'hFFFF_FFFF, 5'd5);
      cycle();
      rd("rsi_new", 12'h340, 32'hDEAD_0005, 1'b0);

      // mcycle low-half carry into high half
      wr(12'hB00, 3'b001, 32'hFFFF_FFFF, 5'd0);
      cycle();
      rd("mcycle_wr",   12'hB00, 32'hFFFF_FFFF, 1'b0);
      rd("mcycleh_wr",  12'hB80, 32'd0, 1'b0);
      cycle();
      rd("mcycle_wrap",  12'hB00, 32'd0, 1'b0);
      rd("mcycleh_wrap", 12'hB80, 32'd1, 1'b0);
      cycle();
      rd("cycle_next",  12'hC00, 32'd1, 1'b0);
      rd("cycleh_next", 12'hC80, 32'd1, 1'b0);
      // Writing the high half leaves the low half counting
      wr(12'hB80, 3'b001, 32'd7, 5'd0);
      cycle();
      rd("mcycle_hiwr",  12'hB00, 32'd2, 1'b0);
      rd("mcycleh_hiwr", 12'hB80, 32'd7, 1'b0);

      // minstret counting and write-over-increment
      repeat (3) begin
         InstrRetiredW = 1'b1;
         cycle();
      end
      rd("minstret_3", 12'hB02, 32'd3, 1'b0);
      InstrRetiredW = 1'b1;
      wr(12'hB02, 3'b001, 32'h10, 5'd0);
      cycle();
      rd("minstret_wr", 12'hB02, 32'h10, 1'b0);

      // Enable MIE, then trap alongside a mscratch write
      wr(12'h300, 3'b110, 32'd0, 5'd8);
      cycle();
      rd("mstatus_mie", 12'h300, 32'h0000_1808, 1'b0);
      chk("mie_o_set", {31'b0, mie_o}, 32'd1);
      TrapW = 1'b1; TrapCauseW = 32'd2; TrapPCW = 32'h0000_1006;
      InstrRetiredW = 1'b1;
      wr(12'h340, 3'b001, 32'h1234_5678, 5'd0);
      cycle();
      chk("mepc_o_trap", mepc_o, 32'h0000_1004);
      rd("mepc_trap",     12'h341, 32'h0000_1004, 1'b0);
      rd("mcause_trap",   12'h342, 32'd2, 1'b0);
      rd("mstatus_trap",  12'h300, 32'h0000_1880, 1'b0);
      chk("mie_o_trap", {31'b0, mie_o}, 32'd0);
      rd("mscratch_trap", 12'h340, 32'hDEAD_0005, 1'b0);
      rd("minstret_trap", 12'hB02, 32'h11, 1'b0);
      // mret wins over a same-cycle mstatus write
      MretW = 1'b1;
      wr(12'h300, 3'b001, 32'd0, 5'd0);
      cycle();
      rd("mstatus_mret", 12'h300, 32'h0000_1888, 1'b0);
      chk("mie_o_mret", {31'b0, mie_o}, 32'd1);

      // Illegal accesses: no state change, counter keeps running
      wr(12'hB00, 3'b001, 32'h100, 5'd0);
      cycle();
      rd("mcycle_set", 12'hB00, 32'h100, 1'b0);
      wr(12'hC00, 3'b001, 32'd0, 5'd0);
      chk("ill_c00", {31'b0, illegal_csrW}, 32'd1);
      chk("ill_c00_rdata", csr_rdataW, 32'h100);
      cycle();
      rd("mcycle_after_c00", 12'hB00, 32'h101, 1'b0);
      wr(12'h7C0, 3'b001, 32'h0000_AAAA, 5'd0);
      chk("ill_7c0", {31'b0, illegal_csrW}, 32'd1);
      chk("ill_7c0_rdata", csr_rdataW, 32'd0);
      cycle();
      rd("mcycle_after_7c0", 12'hB00, 32'h102, 1'b0);
      rd("mscratch_kept",    12'h340, 32'hDEAD_0005, 1'b0);
      rd("rd_7c0",           12'h7C0, 32'd0, 1'b1);
      wr(12'h301, 3'b001, 32'd0, 5'd0);
      chk("ill_misa", {31'b0, illegal_csrW}, 32'd1);
      cycle();
      rd("misa_kept", 12'h301, 32'h4000_0100, 1'b0);

      // mepc / mtvec low bits hardwired to zero
      wr(12'h341, 3'b001, 32'h0000_2003, 5'd0);
      cycle();
      rd("mepc_wr", 12'h341, 32'h0000_2000, 1'b0);
      wr(12'h305, 3'b001, 32'h0000_0203, 5'd0);
      cycle();
      chk("mtvec_o_wr", mtvec_o, 32'h0000_0200);

      // Asynchronous reset mid-cycle
      #4 reset = 1'b1;
      #1;
      chk("mtvec_o_async", mtvec_o, 32'h0000_0100);
      chk("mepc_o_async", mepc_o, 32'd0);
      chk("mie_o_async", {31'b0, mie_o}, 32'd0);
      rd("mstatus_async",  12'h300, 32'h0000_1800, 1'b0);
      rd("mscratch_async", 12'h340, 32'd0, 1'b0);
      rd("mcycle_async",   12'hB00, 32'd0, 1'b0);
      wr(12'h340, 3'b001, 32'h5555_5555, 5'd0);
      cycle();
      rd("mcycle_held",   12'hB00, 32'd0, 1'b0);
      rd("mscratch_held", 12'h340, 32'd0, 1'b0);
      #4 reset = 1'b0;
      cycle();
      rd("mcycle_first", 12'hB00, 32'd1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
